// File: rtl/pr_elastic_stage.sv
// pr_elastic_stage: elastic pipeline register between two adjacent core stages.
// DEPTH-entry circular buffer with a valid/ready handshake on both sides. It
// obeys the hazard-control stall/flush pair and exports a one-cycle look-ahead
// of its output so that a downstream synchronous SRAM can be addressed early.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   i_stall         freeze both sides, hold all state
//   i_flush         drop every entry (wins over i_stall)
//   in_valid/in_ready/in_data     upstream handshake and payload
//   out_valid/out_ready/out_data  downstream handshake and head payload (0 when empty)
//   out_data_next   value out_data will take after the coming posedge
//   occupancy       number of valid entries
module pr_elastic_stage #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [DATA_W-1:0] out_data_next,
    output logic [CNT_W-1:0]  occupancy
);

    localparam int               PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);

    logic [DEPTH-1:0][DATA_W-1:0] mem;
    logic [PTR_W-1:0]             rd_ptr, wr_ptr, rd_nxt, wr_nxt;
    logic [CNT_W-1:0]             count;
    logic                         push, pop;

    // DEPTH need not be a power of two, so wrap explicitly.
    assign rd_nxt = (rd_ptr == LAST) ? '0 : rd_ptr + PTR_W'(1);
    assign wr_nxt = (wr_ptr == LAST) ? '0 : wr_ptr + PTR_W'(1);

    // A full buffer still accepts when its head leaves in the same cycle.
    assign in_ready  = !rst && !i_stall && !i_flush &&
                       (count < FULL || (count != '0 && out_ready));
    assign out_valid = (count != '0) && !i_stall && !i_flush;
    assign pop       = out_valid && out_ready;
    assign push      = in_valid && in_ready;

    assign out_data  = (count == '0) ? '0 : mem[rd_ptr];
    assign occupancy = count;

    // Look-ahead: mirrors what the register update below will present.
    always_comb begin
        out_data_next = out_data;
        if (rst || i_flush)
            out_data_next = '0;
        else if (i_stall)
            out_data_next = out_data;
        else if (pop && count > ONE)
            out_data_next = mem[rd_nxt];
        else if (pop)
            // last entry leaves; a same-cycle push becomes the new head
            out_data_next = push ? in_data : '0;
        else if (count == '0)
            out_data_next = push ? in_data : '0;
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            mem    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            // push/pop are already gated off by i_stall, so stall holds state
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= wr_nxt;
            end
            if (pop)
                rd_ptr <= rd_nxt;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule

// File: tb/tb_pr_elastic_stage.sv
module tb_pr_elastic_stage;

    localparam int DEP [3] = '{1, 2, 3};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall, flush, in_valid, out_ready;
    logic [31:0] in_data;

    logic        ir [3];
    logic        ov [3];
    logic [31:0] od [3];
    logic [31:0] odn[3];
    logic [0:0]  occ1;
    logic [1:0]  occ2, occ3;
    int          occ[3];

    always_comb begin
        occ[0] = int'(occ1);
        occ[1] = int'(occ2);
        occ[2] = int'(occ3);
    end

    pr_elastic_stage #(.DATA_W(32), .DEPTH(1)) u_d1 (
        .clk(clk), .rst(rst), .i_stall(stall), .i_flush(flush),
        .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
        .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
        .out_data_next(odn[0]), .occupancy(occ1));
    pr_elastic_stage #(.DATA_W(32), .DEPTH(2)) u_d2 (
        .clk(clk), .rst(rst), .i_stall(stall), .i_flush(flush),
        .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
        .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
        .out_data_next(odn[1]), .occupancy(occ2));
    pr_elastic_stage #(.DATA_W(32), .DEPTH(3)) u_d3 (
        .clk(clk), .rst(rst), .i_stall(stall), .i_flush(flush),
        .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
        .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]),
        .out_data_next(odn[2]), .occupancy(occ3));

    // Reference: per depth, an ordered list with the head at index 0.
    int          mcnt[3];
    logic [31:0] mbuf[3][16];
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string tag, input int k, input logic [31:0] a, input logic [31:0] e);
        total++;
        assert (a === e) else begin
            bad++;
            $error("FAIL %s depth=%0d got=%h exp=%h", tag, DEP[k], a, e);
        end
    endtask

    // Check all three instances against the model, advance the model, then clock.
    task automatic step();
        logic        ir_e, ov_e, pp, ps;
        logic [31:0] head, saved_odn;
        #1;
        for (int k = 0; k < 3; k++) begin
            ir_e = !rst && !stall && !flush &&
                   (mcnt[k] < DEP[k] || (mcnt[k] > 0 && out_ready));
            ov_e = mcnt[k] > 0 && !stall && !flush;
            head = (mcnt[k] > 0) ? mbuf[k][0] : 32'h0;
            chk("in_ready",  k, 32'(ir[k]), 32'(ir_e));
            chk("out_valid", k, 32'(ov[k]), 32'(ov_e));
            chk("out_data",  k, od[k], head);
            chk("occupancy", k, 32'(occ[k]), 32'(mcnt[k]));
            saved_odn = odn[k];
            if (rst || flush) begin
                mcnt[k] = 0;
            end else if (!stall) begin
                pp = ov_e && out_ready;
                ps = in_valid && ir_e;
                if (pp) begin
                    for (int j = 0; j < 15; j++) mbuf[k][j] = mbuf[k][j+1];
                    mcnt[k]--;
                end
                if (ps) begin
                    mbuf[k][mcnt[k]] = in_data;
                    mcnt[k]++;
                end
            end
            head = (mcnt[k] > 0) ? mbuf[k][0] : 32'h0;
            chk("out_data_next", k, saved_odn, head);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic r, input logic s, input logic f,
                         input logic iv, input logic [31:0] d, input logic ordy);
        rst = r; stall = s; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
        step();
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) mcnt[k] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // reset state, then reset in the middle of traffic
        drive(1, 0, 0, 1, 32'h5, 1);
        drive(0, 0, 0, 1, 32'hA, 0);
        drive(0, 0, 0, 1, 32'hB, 0);
        drive(1, 0, 0, 1, 32'hC, 1);
        drive(0, 0, 0, 0, 32'h0, 1);

        // streaming back-to-back
        for (int i = 1; i <= 8; i++) drive(0, 0, 0, 1, 32'(i), 1);
        repeat (3) drive(0, 0, 0, 0, 32'h0, 1);

        // backpressure to full, then release with the held word
        drive(0, 0, 0, 1, 32'h10, 0);
        drive(0, 0, 0, 1, 32'h11, 0);
        drive(0, 0, 0, 1, 32'h12, 0);
        drive(0, 0, 0, 1, 32'h12, 1);
        repeat (3) drive(0, 0, 0, 0, 32'h0, 1);

        // stall freezes, stall+flush empties
        drive(0, 0, 0, 1, 32'h20, 0);
        drive(0, 0, 0, 1, 32'h21, 0);
        repeat (3) drive(0, 1, 0, 1, 32'h22, 1);
        drive(0, 1, 1, 1, 32'h23, 1);
        drive(0, 0, 0, 0, 32'h0, 1);

        // randomized traffic incl. wrap-around, occasional stall/flush/reset
        for (int i = 0; i < 300; i++)
            drive($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0,
                  $urandom, $urandom_range(0, 2) != 0);

        // single-entry buffer: full throughput, then blocked
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 32'h30 + 32'(i), 1);
        repeat (2) drive(0, 0, 0, 1, 32'h40, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
